// File: rtl/pokey_pkg.sv
// ============================================================================
// pokey_pkg : shared encodings and constants for the POKEY pot scan datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package pokey_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_SCAN = 2'd2
    } pot_state_t;

    localparam int POT_MAX_COUNT  = 228;
    localparam int POT_DUMP_TICKS = 2;

endpackage

`default_nettype wire

// File: rtl/pokey_sync2.sv
// ============================================================================
// pokey_sync2 : parameter-width two-flop synchronizer, async active-low reset
// Rev 1.0
// ============================================================================
`default_nettype none

module pokey_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pokey_pot_scan_ctrl.sv
// ============================================================================
// pokey_pot_scan_ctrl : POTGO sequencer owning dump, line counter, POTn, ALLPOT
// Rev 1.0
// ============================================================================
`default_nettype none

module pokey_pot_scan_ctrl
    import pokey_pkg::*;
#(
    parameter int NUM_POTS   = 8,
    parameter int MAX_COUNT  = POT_MAX_COUNT,
    parameter int DUMP_TICKS = POT_DUMP_TICKS
) (
    input  logic                  o2,
    input  logic                  n_reset,
    input  logic                  potgo_strb,
    input  logic                  init_L,
    input  logic                  fast_scan,
    input  logic                  clk15_en,
    input  logic [NUM_POTS-1:0]   pot_scan,
    output logic                  pot_dump,
    output logic [7:0]            bin_ctr_pot,
    output logic [8*NUM_POTS-1:0] pot_val,
    output logic [NUM_POTS-1:0]   allpot,
    output logic                  scan_busy
);

    localparam logic [7:0] C_MAX8      = 8'(MAX_COUNT);
    localparam logic [7:0] C_DUMP_LAST = 8'(DUMP_TICKS - 1);

    pot_state_t            r_state,    w_state_nxt;
    logic [7:0]            r_dump_cnt, w_dump_nxt;
    logic [7:0]            r_ctr,      w_ctr_nxt;
    logic [8*NUM_POTS-1:0] r_pot_val,  w_val_nxt;
    logic [NUM_POTS-1:0]   r_allpot,   w_allpot_nxt;
    logic [NUM_POTS-1:0]   w_pot_s;
    logic [NUM_POTS-1:0]   w_hit;
    logic [NUM_POTS-1:0]   w_left;
    logic                  w_tick;

    pokey_sync2 #(.WIDTH(NUM_POTS)) u_pot_sync (
        .clk   (o2),
        .rst_n (n_reset),
        .d     (pot_scan),
        .q     (w_pot_s)
    );

    assign w_tick = fast_scan ? 1'b1 : clk15_en;

    always_comb begin
        w_state_nxt  = r_state;
        w_dump_nxt   = r_dump_cnt;
        w_ctr_nxt    = r_ctr;
        w_val_nxt    = r_pot_val;
        w_allpot_nxt = r_allpot;
        w_hit        = '0;
        w_left       = '0;

        if (!init_L) begin
            w_state_nxt  = ST_IDLE;
            w_ctr_nxt    = '0;
            w_allpot_nxt = '0;
        end else if (potgo_strb) begin
            w_state_nxt  = ST_DUMP;
            w_dump_nxt   = '0;
            w_ctr_nxt    = '0;
            w_allpot_nxt = '1;
        end else if (w_tick) begin
            case (r_state)
                ST_DUMP: begin
                    if (r_dump_cnt == C_DUMP_LAST)
                        w_state_nxt = ST_SCAN;
                    else
                        w_dump_nxt = r_dump_cnt + 8'd1;
                end
                ST_SCAN: begin
                    w_hit  = r_allpot & w_pot_s;
                    w_left = r_allpot & ~w_hit;
                    for (int n = 0; n < NUM_POTS; n++) begin
                        if (w_hit[n])
                            w_val_nxt[8*n +: 8] = r_ctr;
                    end
                    // Terminal count: pots that never crossed threshold read MAX_COUNT
                    if (r_ctr == C_MAX8) begin
                        for (int n = 0; n < NUM_POTS; n++) begin
                            if (w_left[n])
                                w_val_nxt[8*n +: 8] = C_MAX8;
                        end
                        w_allpot_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                    end else if (w_left == '0) begin
                        w_allpot_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_allpot_nxt = w_left;
                        w_ctr_nxt    = r_ctr + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge o2 or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= ST_IDLE;
            r_dump_cnt <= '0;
            r_ctr      <= '0;
            r_pot_val  <= '0;
            r_allpot   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dump_cnt <= w_dump_nxt;
            r_ctr      <= w_ctr_nxt;
            r_pot_val  <= w_val_nxt;
            r_allpot   <= w_allpot_nxt;
        end
    end

    assign pot_dump    = (r_state != ST_SCAN);
    assign scan_busy   = (r_state != ST_IDLE);
    assign bin_ctr_pot = r_ctr;
    assign pot_val     = r_pot_val;
    assign allpot      = r_allpot;

endmodule

`default_nettype wire
